// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path types: FSM state encoding, sticky error bundle and
// the idle-timeout length in characters.
package uart_defs;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } RxState_t;

  typedef struct packed {
    logic overrun;
    logic frame;
    logic parity;
  } RxErr_t;

  localparam int TIMEOUT_CHARS = 4;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fallthrough FIFO; head data reads as 0 while empty.
// Shared between the UART receive and transmit paths.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      level_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign valid_o    = (level_q != '0);
  assign full       = (level_q == FULL_LVL);
  assign do_pop     = pop_i && valid_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push    = push_i && (!full || do_pop);
  assign overflow_o = push_i && full && !do_pop;
  assign rdata_o    = valid_o ? mem_q[rd_q] : '0;
  assign level_o    = level_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority vote, FWFT receive FIFO, sticky
// errors and RTS. Optional idle-character timeout: define UART_RX_TIMEOUT_EN.
module uart_rx_fifo
  import uart_defs::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OSR        = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx_i,
  input  logic                            enable_i,
  input  logic [DIV_W-1:0]                divider_i,
  input  logic                            parity_en_i,
  input  logic                            parity_odd_i,
  input  logic                            stop2_i,
  output logic [DATA_BITS-1:0]            rx_d_o,
  output logic                            rx_d_valid_o,
  input  logic                            rx_d_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]     level_o,
  input  logic [$clog2(FIFO_DEPTH):0]     watermark_i,
  output logic                            irq_o,
  output logic                            rts_n_o,
  output logic                            parity_err_o,
  output logic                            frame_err_o,
  output logic                            overrun_o,
  input  logic                            status_clr_i,
  output logic                            timeout_o,
  output RxState_t                        dbg_state_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(OSR);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_ONE   = SW'(1);
  localparam logic [SW-1:0] S_LAST  = SW'(OSR - 1);
  localparam logic [SW-1:0] S_V0    = SW'(OSR/2 - 1);
  localparam logic [SW-1:0] S_V1    = SW'(OSR/2);
  localparam logic [SW-1:0] S_V2    = SW'(OSR/2 + 1);
  localparam logic [BW-1:0] B_ONE   = BW'(1);
  localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);
  localparam logic [LW-1:0] RTS_LVL = LW'(FIFO_DEPTH - 2);
  localparam logic [DIV_W-1:0] D_ONE = DIV_W'(1);

  logic [1:0]           sync_q;
  logic                 rxs;
  logic [DIV_W-1:0]     div_cnt_q;
  logic                 tick;
  RxState_t             state_q;
  logic [SW-1:0]        s_q;
  logic [2:0]           v_q;
  logic [DATA_BITS-1:0] data_q;
  logic [BW-1:0]        bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 par_en_q, par_odd_q, stop2_q;
  logic                 pend_par_q, pend_frame_q;
  logic                 line_ok_q;
  logic                 vote, bit_end, push, start_go;
  logic                 fifo_ovf;
  logic [LW-1:0]        level;
  RxErr_t               err_q, err_set;
  logic [2:0]           err_keep;
  logic                 rts_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_i};
  end
  assign rxs = sync_q[1];

  assign tick = enable_i && (div_cnt_q == divider_i);
  always_ff @(posedge clk) begin
    if (!rst_n || !enable_i) div_cnt_q <= '0;
    else if (tick)           div_cnt_q <= '0;
    else                     div_cnt_q <= div_cnt_q + D_ONE;
  end

  assign vote     = (v_q[0] & v_q[1]) | (v_q[0] & v_q[2]) | (v_q[1] & v_q[2]);
  assign bit_end  = tick && (state_q != IDLE) && (s_q == S_LAST);
  assign push     = bit_end && (state_q == STOP) && (!stop2_q || stop_cnt_q);
  // A start is only accepted once the line has been seen idle, so a held
  // break does not retrigger frames back to back.
  assign start_go = tick && (state_q == IDLE) && !rxs && line_ok_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s_q          <= '0;
      v_q          <= 3'b111;
      data_q       <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      stop2_q      <= 1'b0;
      pend_par_q   <= 1'b0;
      pend_frame_q <= 1'b0;
      line_ok_q    <= 1'b0;
    end else if (!enable_i) begin
      state_q      <= IDLE;
      s_q          <= '0;
      pend_par_q   <= 1'b0;
      pend_frame_q <= 1'b0;
      line_ok_q    <= 1'b0;
    end else if (tick) begin
      if (state_q != IDLE) begin
        s_q <= (s_q == S_LAST) ? '0 : s_q + S_ONE;
        if (s_q == S_V0) v_q[0] <= rxs;
        if (s_q == S_V1) v_q[1] <= rxs;
        if (s_q == S_V2) v_q[2] <= rxs;
      end
      case (state_q)
        IDLE: begin
          if (start_go) begin
            state_q      <= START;
            s_q          <= '0;
            par_en_q     <= parity_en_i;
            par_odd_q    <= parity_odd_i;
            stop2_q      <= stop2_i;
            pend_par_q   <= 1'b0;
            pend_frame_q <= 1'b0;
          end else if (rxs) begin
            line_ok_q <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q   <= vote ? IDLE : DATA;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            data_q     <= {vote, data_q[DATA_BITS-1:1]};
            bit_cnt_q  <= bit_cnt_q + B_ONE;
            stop_cnt_q <= 1'b0;
            if (bit_cnt_q == B_LAST) state_q <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_end) begin
            if (vote != (^data_q ^ par_odd_q)) pend_par_q <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!vote) pend_frame_q <= 1'b1;
            stop_cnt_q <= 1'b1;
            if (push) begin
              state_q   <= IDLE;
              line_ok_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign dbg_state_o = state_q;

  // rx_d_o/rx_d_valid_o form a valid/ready pair: a character is consumed on
  // any clk where both are high; valid never drops without a pop.
  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .wdata_i    (data_q),
    .pop_i      (rx_d_ready_i),
    .rdata_o    (rx_d_o),
    .valid_o    (rx_d_valid_o),
    .level_o    (level),
    .overflow_o (fifo_ovf)
  );
  assign level_o = level;

  always_comb begin
    err_set         = '0;
    err_set.overrun = fifo_ovf;
    err_set.frame   = push && (pend_frame_q || !vote);
    err_set.parity  = push && pend_par_q;
  end

  assign err_keep = status_clr_i ? 3'b000 : err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= RxErr_t'(err_keep | err_set);
  end
  assign parity_err_o = err_q.parity;
  assign frame_err_o  = err_q.frame;
  assign overrun_o    = err_q.overrun;

  assign irq_o = (watermark_i != '0) && (level >= watermark_i);

  always_ff @(posedge clk) begin
    if (!rst_n) rts_q <= 1'b1;
    else        rts_q <= !enable_i || (level >= RTS_LVL);
  end
  assign rts_n_o = rts_q;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_BITS = TIMEOUT_CHARS * (2 + DATA_BITS);
  localparam int TW      = $clog2(TO_BITS + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TO_BITS);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);

  logic [SW-1:0] to_sub_q;
  logic [TW-1:0] to_cnt_q;
  logic          to_clr, to_run;

  assign to_clr = !enable_i || (rx_d_ready_i && rx_d_valid_o) || start_go;
  assign to_run = tick && (state_q == IDLE) && (level != '0) && (level < watermark_i);

  // Counts whole bit periods of idle line while a partial batch sits unread.
  always_ff @(posedge clk) begin
    if (!rst_n || to_clr) begin
      to_sub_q <= '0;
      to_cnt_q <= '0;
    end else if (to_run) begin
      to_sub_q <= (to_sub_q == S_LAST) ? '0 : to_sub_q + S_ONE;
      if ((to_sub_q == S_LAST) && (to_cnt_q != TO_LIMIT)) to_cnt_q <= to_cnt_q + TO_ONE;
    end
  end
  assign timeout_o = (to_cnt_q == TO_LIMIT);
`else
  assign timeout_o = 1'b0;
`endif

endmodule
